// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl
// Accepts one move command at a time (direction, step count, period) and
// emits evenly spaced one-cycle step strobes to a phase sequencer. It keeps a
// wrapping 16-bit signed position and reports completion with a done strobe.
// The period is clamped so the sequencer is never stepped faster than
// MIN_PERIOD allows.
module stepper_move_ctrl #(
  parameter int MIN_PERIOD = 22000,
  parameter int PERIOD_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [15:0]         cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                step_pulse,
  output logic                step_dir,
  output logic                busy,
  output logic                done,
  output logic [15:0]         position
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

  logic [1:0]          state_reg;
  logic [PERIOD_W-1:0] period_reg;    // effective period latched at acceptance
  logic [PERIOD_W-1:0] cnt_reg;       // cycles left until the next step edge
  logic [15:0]         remain_reg;    // steps still to issue
  logic                dir_reg;       // direction latched at acceptance
  logic                step_pulse_reg;
  logic                step_dir_reg;
  logic [15:0]         position_reg;

  logic [PERIOD_W-1:0] eff_period;
  logic                fire;

  // Clamp the requested period and decide whether this edge issues a step.
  // An abort at the same edge as a due step suppresses that step.
  always_comb begin
    eff_period = cmd_period;
    if (cmd_period < MIN_P) begin
      eff_period = MIN_P;
    end
    fire = (state_reg == S_RUN) && !abort && (remain_reg != 16'd0) &&
           (cnt_reg == '0);
  end

  // Move sequencing: command capture, step spacing and the IDLE/RUN/DONE FSM.
  // The counter is loaded with P-1 at acceptance so the first step edge lands
  // exactly P edges after the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      period_reg <= '0;
      cnt_reg    <= '0;
      remain_reg <= 16'd0;
      dir_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            dir_reg    <= cmd_dir;
            period_reg <= eff_period;
            cnt_reg    <= eff_period - ONE_P;
            remain_reg <= cmd_steps;
            state_reg  <= (cmd_steps == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (abort || remain_reg == 16'd0) begin
            state_reg <= S_DONE;
          end else if (cnt_reg == '0) begin
            remain_reg <= remain_reg - 16'd1;
            cnt_reg    <= period_reg - ONE_P;
          end else begin
            cnt_reg <= cnt_reg - ONE_P;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Step strobe, its direction and the position update all land on one edge;
  // step_dir holds its last value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pulse_reg <= 1'b0;
      step_dir_reg   <= 1'b0;
      position_reg   <= 16'd0;
    end else begin
      step_pulse_reg <= fire;
      if (fire) begin
        step_dir_reg <= dir_reg;
        position_reg <= dir_reg ? (position_reg + 16'd1) : (position_reg - 16'd1);
      end
    end
  end

  assign cmd_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg == S_RUN);
  assign done       = (state_reg == S_DONE);
  assign step_pulse = step_pulse_reg;
  assign step_dir   = step_dir_reg;
  assign position   = position_reg;

endmodule
